ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Owns the single write/read port of the 64 KB main-RAM spram.
- Sequences a power-on/reset clear of the whole array, then time-shares the port:
  - the Oric core (CPU/ULA) gets passthrough access;
  - a fast-load injector (TAP bytes written straight into RAM) gets the idle slots.
- Sits between the core's ram_ad/ram_d/ram_we outputs and the spram; replaces the ad-hoc clear logic in the top level.

Parameters:
- ADDR_W, 16, RAM address width; the array holds 2^ADDR_W bytes.
- CLEAR_VAL, 8'h01, byte written to every location during clear.

Ports:
- clk_sys  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- start_clear  in  1  one-cycle request to re-run the clear sequence
- cpu_ad  in  ADDR_W  core address
- cpu_d  in  8  core write data
- cpu_we  in  1  core write enable
- cpu_free  in  1  core is not using RAM this cycle (a slot is available)
- inj_req  in  1  injector write request; level, held until acked
- inj_addr  in  ADDR_W  injector address; stable while inj_req is high
- inj_data  in  8  injector data; stable while inj_req is high
- inj_ack  out  1  one-cycle pulse; the inject write was issued
- ram_ad  out  ADDR_W  registered spram address
- ram_d  out  8  registered spram write data
- ram_we  out  1  registered spram write enable
- clearing  out  1  high while the clear sequence runs; the top level holds the core in reset with it
- clear_done  out  1  one-cycle pulse when the clear sequence finishes

Behaviour:
- States: CLEAR, RUN.
- RESET (synchronous, wins over everything):
  - state goes to CLEAR, counter=0;
  - ram_we=0, ram_ad=0, ram_d=CLEAR_VAL, inj_ack=0, clear_done=0, clearing=1.
- CLEAR:
  - Every cycle registers ram_ad=cnt, ram_d=CLEAR_VAL, ram_we=1, then cnt+1.
  - Exactly 2^ADDR_W writes, addresses 0..2^ADDR_W-1 in order.
  - After the write of the all-ones address: state goes to RUN, clearing goes to 0 the same cycle, and clear_done pulses for 1 cycle.
  - cnt is ADDR_W wide. The "last" flag is cnt==all-ones; no wrap to 0 is ever issued as a write.
  - cpu_we and inj_req are ignored, and no inj_ack is issued.
  - start_clear (or RESET) during CLEAR restarts at cnt=0.
- RUN, with priority per cycle:
  1. start_clear: the state goes to CLEAR, cnt=0, ram_we=0 this cycle; the first clear write comes on the next cycle.
  2. cpu_free & inj_req: ram_ad=inj_addr, ram_d=inj_data, ram_we=1, and inj_ack=1 in the same registered cycle.
  3. Otherwise passthrough: ram_ad=cpu_ad, ram_d=cpu_d, ram_we=cpu_we.
- Latency:
  - All ram_* outputs are registered, so there is 1 clk_sys of latency from the inputs.
  - The core read path (spram q) is untouched by this block.
- Injector handshake:
  - The requester must drop inj_req or present a new address the cycle after inj_ack.
  - An inj_req still high with the same address after ack is treated as a new request. It is the requester's fault and is documented, not guarded.
- Simultaneous events:
  - cpu_free=0 with inj_req=1 → passthrough; the inject waits.
  - start_clear with inj_req in the same cycle → clear wins, no ack.
- Mid-operation reset: any pending inj_req is dropped silently. The requester re-issues after clearing=0.

Optional Feature:
- Macro RAM_CLEAR_PATTERN_EN.
- Defined: the clear data follows the real Oric power-up pattern, ram_d = (cnt[7] ? 8'hFF : 8'h00). CLEAR_VAL is unused.
- Undefined: every location gets CLEAR_VAL.
- Sequence length, timing and handshakes are identical in both builds.

Decomposition:
- Package oric_ram_pkg:
  - arb_state_t enum {CLEAR, RUN};
  - localparams for the clear pattern bytes (8'h00/8'hFF).
- No sub-module: one counter plus a two-state FSM in a single always block, with a small function for clear-data selection.

Test Plan:
- Clear after reset: RESET high 1 cycle → exactly 65536 writes with ram_we=1, addresses 0..FFFF ascending, data 8'h01; then clearing falls and clear_done pulses once.
- Passthrough: in RUN, cpu_ad=16'h0400, cpu_d=8'hA5, cpu_we=1 → one cycle later ram_ad=0400, ram_d=A5, ram_we=1.
- Inject arbitration: inj_req with addr 16'h0501, data 8'h3C, and cpu_free=0 for 3 cycles, then 1 → no ack while cpu_free=0; then ram_ad=0501, ram_d=3C, ram_we=1 with inj_ack=1 for exactly 1 cycle.
- Clear during RUN with pending inject: start_clear and inj_req in the same cycle → no inj_ack; clear restarts at 0000; inject served only after clear_done.
- Reset mid-clear: RESET at cnt=16'h1234 → the next write address is 0000 and the total write count after RESET is 65536.
- RAM_CLEAR_PATTERN_EN build: writes to 007F, 0080 and 00FF carry 00, FF and FF respectively.

Source files
------------

// File: rtl/ram_port_arbiter_pkg.sv
// oric_ram_pkg: shared state type and clear-pattern constants for the main-RAM port arbiter
package oric_ram_pkg;
  typedef enum logic {CLEAR, RUN} arb_state_t;
  localparam logic [7:0] PAT_LO = 8'h00;
  localparam logic [7:0] PAT_HI = 8'hFF;
  function automatic logic [7:0] pat_byte(input logic hi);
    return hi ? PAT_HI : PAT_LO;
  endfunction
endpackage

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: clears main RAM after reset, then shares its port between the core and the TAP injector (RAM_CLEAR_PATTERN_EN selects the Oric power-up clear pattern)
module ram_port_arbiter
  import oric_ram_pkg::*;
#(
  parameter int         ADDR_W    = 16,
  parameter logic [7:0] CLEAR_VAL = 8'h01
) (
  input  logic              clk_sys,
  input  logic              RESET,
  input  logic              start_clear,
  input  logic [ADDR_W-1:0] cpu_ad,
  input  logic [7:0]        cpu_d,
  input  logic              cpu_we,
  input  logic              cpu_free,
  input  logic              inj_req,
  input  logic [ADDR_W-1:0] inj_addr,
  input  logic [7:0]        inj_data,
  output logic              inj_ack,
  output logic [ADDR_W-1:0] ram_ad,
  output logic [7:0]        ram_d,
  output logic              ram_we,
  output logic              clearing,
  output logic              clear_done
);
  arb_state_t        state;
  logic [ADDR_W-1:0] cnt;
  logic [7:0]        clr_d;
`ifdef RAM_CLEAR_PATTERN_EN
  assign clr_d = pat_byte(cnt[7]);
`else
  assign clr_d = CLEAR_VAL;
`endif
  // clear sweep, then clear request > inject in a free slot > core passthrough
  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      state      <= CLEAR;
      cnt        <= '0;
      ram_we     <= 1'b0;
      ram_ad     <= '0;
      ram_d      <= CLEAR_VAL;
      inj_ack    <= 1'b0;
      clear_done <= 1'b0;
      clearing   <= 1'b1;
    end else begin
      inj_ack    <= 1'b0;
      clear_done <= 1'b0;
      if (start_clear) begin
        state    <= CLEAR;
        cnt      <= '0;
        ram_we   <= 1'b0;
        clearing <= 1'b1;
      end else if (state == CLEAR) begin
        ram_ad <= cnt;
        ram_d  <= clr_d;
        ram_we <= 1'b1;
        cnt    <= cnt + 1'b1;
        if (&cnt) begin
          state      <= RUN;
          clearing   <= 1'b0;
          clear_done <= 1'b1;
        end
      end else if (cpu_free && inj_req) begin
        ram_ad  <= inj_addr;
        ram_d   <= inj_data;
        ram_we  <= 1'b1;
        inj_ack <= 1'b1;
      end else begin
        ram_ad <= cpu_ad;
        ram_d  <= cpu_d;
        ram_we <= cpu_we;
      end
    end
  end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed vector bench for ram_port_arbiter (12-bit address build keeps clear sweeps short)
module tb_ram_port_arbiter;
  localparam int AW = 12;
  localparam int N  = 1 << AW;
  typedef struct {
    logic          free;
    logic [AW-1:0] cad;
    logic [7:0]    cd;
    logic          cwe;
    logic          req;
    logic [AW-1:0] iad;
    logic [7:0]    id;
    logic [AW-1:0] ead;
    logic [7:0]    ed;
    logic          ewe;
    logic          eack;
  } vec_t;
  logic clk_sys = 1'b0;
  logic RESET = 1'b1;
  logic start_clear = 1'b0;
  logic [AW-1:0] cpu_ad = '0;
  logic [AW-1:0] inj_addr = '0;
  logic [7:0] cpu_d = '0;
  logic [7:0] inj_data = '0;
  logic cpu_we = 1'b0;
  logic cpu_free = 1'b0;
  logic inj_req = 1'b0;
  logic inj_ack, ram_we, clearing, clear_done;
  logic [AW-1:0] ram_ad;
  logic [7:0] ram_d;
  int errors = 0;
  int checks = 0;
  vec_t v[8];
  always #5 clk_sys = ~clk_sys;
  ram_port_arbiter #(.ADDR_W(AW), .CLEAR_VAL(8'h01)) dut (
    .clk_sys(clk_sys), .RESET(RESET), .start_clear(start_clear),
    .cpu_ad(cpu_ad), .cpu_d(cpu_d), .cpu_we(cpu_we), .cpu_free(cpu_free),
    .inj_req(inj_req), .inj_addr(inj_addr), .inj_data(inj_data), .inj_ack(inj_ack),
    .ram_ad(ram_ad), .ram_d(ram_d), .ram_we(ram_we),
    .clearing(clearing), .clear_done(clear_done)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask
  task automatic run_clear(input string tag);
    int idx = 0;
    int bad = 0;
    int acks = 0;
    bit done = 0;
    bit fell = 0;
    logic [7:0] exp_d;
    logic [7:0] d7f = '0;
    logic [7:0] d80 = '0;
    logic [7:0] dff = '0;
    for (int c = 0; c < N + 8 && !done; c++) begin
      step();
      if (inj_ack) acks++;
      if (ram_we) begin
`ifdef RAM_CLEAR_PATTERN_EN
        exp_d = idx[7] ? 8'hFF : 8'h00;
`else
        exp_d = 8'h01;
`endif
        if (ram_ad !== idx[AW-1:0] || ram_d !== exp_d) bad++;
        if (ram_ad == 12'h07F) d7f = ram_d;
        if (ram_ad == 12'h080) d80 = ram_d;
        if (ram_ad == 12'h0FF) dff = ram_d;
        idx++;
      end
      if (clear_done) begin
        done = 1;
        fell = !clearing;
      end else if (!clearing) bad++;
    end
    chk({tag, " clear_done seen"}, 32'(done), 1);
    chk({tag, " write count"}, idx, N);
    chk({tag, " bad writes"}, bad, 0);
    chk({tag, " acks during clear"}, acks, 0);
    chk({tag, " clearing fell with done"}, 32'(fell), 1);
`ifdef RAM_CLEAR_PATTERN_EN
    chk({tag, " pattern 07F"}, d7f, 8'h00);
    chk({tag, " pattern 080"}, d80, 8'hFF);
    chk({tag, " pattern 0FF"}, dff, 8'hFF);
`else
    chk({tag, " data 0FF"}, dff, 8'h01);
`endif
  endtask
  initial begin
    v[0] = '{1'b0, 12'h400, 8'hA5, 1'b1, 1'b0, 12'h000, 8'h00, 12'h400, 8'hA5, 1'b1, 1'b0};
    v[1] = '{1'b1, 12'h123, 8'h5A, 1'b0, 1'b0, 12'h000, 8'h00, 12'h123, 8'h5A, 1'b0, 1'b0};
    v[2] = '{1'b0, 12'h222, 8'h11, 1'b1, 1'b1, 12'h501, 8'h3C, 12'h222, 8'h11, 1'b1, 1'b0};
    v[3] = '{1'b0, 12'h223, 8'h12, 1'b0, 1'b1, 12'h501, 8'h3C, 12'h223, 8'h12, 1'b0, 1'b0};
    v[4] = '{1'b0, 12'h224, 8'h13, 1'b1, 1'b1, 12'h501, 8'h3C, 12'h224, 8'h13, 1'b1, 1'b0};
    v[5] = '{1'b1, 12'h225, 8'h14, 1'b0, 1'b1, 12'h501, 8'h3C, 12'h501, 8'h3C, 1'b1, 1'b1};
    v[6] = '{1'b1, 12'h300, 8'h77, 1'b0, 1'b0, 12'h501, 8'h3C, 12'h300, 8'h77, 1'b0, 1'b0};
    v[7] = '{1'b1, 12'h301, 8'h66, 1'b1, 1'b1, 12'hFFF, 8'hEE, 12'hFFF, 8'hEE, 1'b1, 1'b1};
    // reset state
    step();
    chk("reset ram_we", 32'(ram_we), 0);
    chk("reset ram_ad", 32'(ram_ad), 0);
    chk("reset ram_d", 32'(ram_d), 8'h01);
    chk("reset clearing", 32'(clearing), 1);
    chk("reset clear_done", 32'(clear_done), 0);
    chk("reset inj_ack", 32'(inj_ack), 0);
    // clear after reset, core and injector active but ignored
    RESET = 1'b0;
    cpu_we = 1'b1; cpu_ad = 12'hABC; cpu_d = 8'h99;
    inj_req = 1'b1; inj_addr = 12'h555; inj_data = 8'h42;
    run_clear("power_on");
    inj_req = 1'b0; cpu_we = 1'b0;
    step();
    chk("done single pulse", 32'(clear_done), 0);
    chk("clearing stays low", 32'(clearing), 0);
    // run-mode vectors
    for (int i = 0; i < 8; i++) begin
      cpu_free = v[i].free; cpu_ad = v[i].cad; cpu_d = v[i].cd; cpu_we = v[i].cwe;
      inj_req = v[i].req; inj_addr = v[i].iad; inj_data = v[i].id;
      step();
      chk($sformatf("vec%0d ram_ad", i), 32'(ram_ad), 32'(v[i].ead));
      chk($sformatf("vec%0d ram_d", i), 32'(ram_d), 32'(v[i].ed));
      chk($sformatf("vec%0d ram_we", i), 32'(ram_we), 32'(v[i].ewe));
      chk($sformatf("vec%0d inj_ack", i), 32'(inj_ack), 32'(v[i].eack));
    end
    // start_clear with a pending inject: clear wins, inject served after clear_done
    cpu_free = 1'b1; cpu_we = 1'b0;
    inj_req = 1'b1; inj_addr = 12'h0A5; inj_data = 8'hC3;
    start_clear = 1'b1;
    step();
    chk("start_clear no ack", 32'(inj_ack), 0);
    chk("start_clear ram_we", 32'(ram_we), 0);
    chk("start_clear clearing", 32'(clearing), 1);
    start_clear = 1'b0;
    run_clear("restart");
    step();
    chk("post-clear inj_ack", 32'(inj_ack), 1);
    chk("post-clear ram_ad", 32'(ram_ad), 12'h0A5);
    chk("post-clear ram_d", 32'(ram_d), 8'hC3);
    chk("post-clear ram_we", 32'(ram_we), 1);
    inj_req = 1'b0;
    step();
    chk("ack one cycle", 32'(inj_ack), 0);
    // reset in the middle of a clear sweep
    start_clear = 1'b1;
    step();
    start_clear = 1'b0;
    begin
      bit hit = 0;
      for (int c = 0; c < N + 8 && !hit; c++) begin
        step();
        hit = ram_we && ram_ad == 12'h234;
      end
      chk("mid-clear reached 234", 32'(hit), 1);
    end
    RESET = 1'b1;
    step();
    chk("mid reset ram_we", 32'(ram_we), 0);
    chk("mid reset ram_ad", 32'(ram_ad), 0);
    chk("mid reset clearing", 32'(clearing), 1);
    RESET = 1'b0;
    run_clear("rst_mid");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
